// File: rtl/instr_register_pkg.sv
// instr_register_pkg
// Shared definitions for the instruction register with execute stage:
//   opcode_t     - 4-bit opcode encoding (codes 8..15 are reserved)
//   opcode_name  - 5-character ASCII mnemonic for an opcode, for log output
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  localparam int OPCODE_W = 4;

  // Fixed-width packed string keeps this usable outside simulation.
  function automatic logic [39:0] opcode_name(input logic [3:0] opc);
    logic [39:0] name;
    case (opc)
      ZERO:    name = "ZERO ";
      PASSA:   name = "PASSA";
      PASSB:   name = "PASSB";
      ADD:     name = "ADD  ";
      SUB:     name = "SUB  ";
      MULT:    name = "MULT ";
      DIV:     name = "DIV  ";
      MOD:     name = "MOD  ";
      default: name = "RSVD ";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/instr_alu.sv
// instr_alu
// Combinational execute unit for one instruction. All arithmetic is carried
// out at RESULT_W = 2*OPERAND_W on sign-extended operands, so ADD/SUB/MULT
// never overflow and DIV of the most negative value by -1 is representable.
// Ports:
//   opc     in   4          opcode (reserved codes give 0)
//   a, b    in   OPERAND_W  signed operands
//   result  out  RESULT_W   signed result
//   div_err out  1          DIV/MOD with b == 0
module instr_alu
  import instr_register_pkg::*;
#(
  parameter  int OPERAND_W = 32,
  localparam int RESULT_W  = 2 * OPERAND_W
) (
  input  logic        [OPCODE_W-1:0]  opc,
  input  logic signed [OPERAND_W-1:0] a,
  input  logic signed [OPERAND_W-1:0] b,
  output logic signed [RESULT_W-1:0]  result,
  output logic                        div_err
);

  logic signed [RESULT_W-1:0] w_a_ext;
  logic signed [RESULT_W-1:0] w_b_ext;
  logic                       w_b_zero;

  assign w_a_ext  = {{OPERAND_W{a[OPERAND_W-1]}}, a};
  assign w_b_ext  = {{OPERAND_W{b[OPERAND_W-1]}}, b};
  assign w_b_zero = (b == '0);

  always_comb begin
    result  = '0;
    div_err = 1'b0;
    case (opc)
      PASSA: result = w_a_ext;
      PASSB: result = w_b_ext;
      ADD:   result = w_a_ext + w_b_ext;
      SUB:   result = w_a_ext - w_b_ext;
      MULT:  result = w_a_ext * w_b_ext;
      // Divider is only consulted when b is non-zero; the zero case is
      // flagged rather than computed.
      DIV: begin
        if (w_b_zero) div_err = 1'b1;
        else          result  = w_a_ext / w_b_ext;
      end
      MOD: begin
        if (w_b_zero) div_err = 1'b1;
        else          result  = w_a_ext % w_b_ext;
      end
      default: result = '0;  // ZERO and reserved codes
    endcase
  end

endmodule

// File: rtl/instr_register_exec.sv
// instr_register_exec
// DEPTH-entry instruction store. Each write captures {opc, op_a, op_b} plus
// the result and divide-by-zero flag computed by instr_alu on the way in.
// Reads are registered with write-first bypass and per-entry valid tracking.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load_en, write_pointer, opcode, operand_a, operand_b   write side
//   read_en, read_pointer                                   read side
//   instruction_word      {opc, op_a, op_b, result, div_err}, registered
//   read_valid            one cycle after an accepted read
//   entry_valid           entry read had been written since reset
//   write_count           writes since reset, saturating at 16'hFFFF
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter  int DEPTH     = 32,
  parameter  int OPERAND_W = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int RESULT_W  = 2 * OPERAND_W,
  localparam int WORD_W    = OPCODE_W + 2 * OPERAND_W + RESULT_W + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  input  logic        [AW-1:0]        write_pointer,
  input  logic        [OPCODE_W-1:0]  opcode,
  input  logic signed [OPERAND_W-1:0] operand_a,
  input  logic signed [OPERAND_W-1:0] operand_b,
  input  logic                        read_en,
  input  logic        [AW-1:0]        read_pointer,
  output logic        [WORD_W-1:0]    instruction_word,
  output logic                        read_valid,
  output logic                        entry_valid,
  output logic        [15:0]          write_count
);

  typedef struct packed {
    logic        [OPCODE_W-1:0]  opc;
    logic signed [OPERAND_W-1:0] op_a;
    logic signed [OPERAND_W-1:0] op_b;
    logic signed [RESULT_W-1:0]  result;
    logic                        div_err;
  } instruction_t;

  instruction_t              w_new_entry;
  logic signed [RESULT_W-1:0] w_alu_result;
  logic                      w_alu_div_err;
  instruction_t              w_entries [DEPTH];
  logic        [DEPTH-1:0]   w_valid;
  logic                      w_bypass;

  instruction_t              r_word;
  logic                      r_entry_valid;
  logic                      r_read_valid;
  logic        [15:0]        r_write_count;

  instr_alu #(
    .OPERAND_W (OPERAND_W)
  ) u_alu (
    .opc     (opcode),
    .a       (operand_a),
    .b       (operand_b),
    .result  (w_alu_result),
    .div_err (w_alu_div_err)
  );

  assign w_new_entry = '{opc:     opcode,
                         op_a:    operand_a,
                         op_b:    operand_b,
                         result:  w_alu_result,
                         div_err: w_alu_div_err};

  // Storage is flops rather than RAM: every entry and valid bit must clear
  // asynchronously on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [AW-1:0] ENTRY_ADDR = AW'(gi);

    instruction_t r_entry;
    logic         r_valid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_entry <= '0;
        r_valid <= 1'b0;
      end else if (load_en && (write_pointer == ENTRY_ADDR)) begin
        r_entry <= w_new_entry;
        r_valid <= 1'b1;
      end
    end

    assign w_entries[gi] = r_entry;
    assign w_valid[gi]   = r_valid;
  end

  // Same-edge write and read of one address returns the incoming entry.
  assign w_bypass = load_en && read_en && (write_pointer == read_pointer);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word        <= '0;
      r_entry_valid <= 1'b0;
      r_read_valid  <= 1'b0;
    end else begin
      r_read_valid <= read_en;
      if (read_en) begin
        if (w_bypass) begin
          r_word        <= w_new_entry;
          r_entry_valid <= 1'b1;
        end else begin
          r_word        <= w_entries[read_pointer];
          r_entry_valid <= w_valid[read_pointer];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_count <= '0;
    end else if (load_en && (r_write_count != 16'hFFFF)) begin
      r_write_count <= r_write_count + 16'd1;
    end
  end

  assign instruction_word = r_word;
  assign entry_valid      = r_entry_valid;
  assign read_valid       = r_read_valid;
  assign write_count      = r_write_count;

endmodule

// File: tb/tb_instr_register_exec.sv
// tb_instr_register_exec
// Self-checking bench: a default instance (DEPTH=32, OPERAND_W=32) exercised
// with directed and random traffic against an array/arithmetic reference
// model, plus a small instance (DEPTH=4, OPERAND_W=8) for narrow arithmetic
// and write_count saturation.
module tb_instr_register_exec;
  import instr_register_pkg::*;

  logic clk;
  logic reset;

  // Default instance
  logic         b_load_en, b_read_en;
  logic [4:0]   b_wp, b_rp;
  logic [3:0]   b_opc;
  logic [31:0]  b_a, b_b;
  logic [132:0] b_word;
  logic         b_rv, b_ev;
  logic [15:0]  b_wc;

  // Small instance
  logic         s_load_en, s_read_en;
  logic [1:0]   s_wp, s_rp;
  logic [3:0]   s_opc;
  logic [7:0]   s_a, s_b;
  logic [36:0]  s_word;
  logic         s_rv, s_ev;
  logic [15:0]  s_wc;

  int vectors;
  int miscompares;

  // Reference model state for the default instance
  logic [132:0] mem_b [32];
  bit           val_b [32];
  logic [132:0] exp_word;
  bit           exp_ev;
  int           exp_wc;

  instr_register_exec #(.DEPTH(32), .OPERAND_W(32)) u_dut_big (
    .clk (clk), .reset (reset),
    .load_en (b_load_en), .write_pointer (b_wp), .opcode (b_opc),
    .operand_a (b_a), .operand_b (b_b),
    .read_en (b_read_en), .read_pointer (b_rp),
    .instruction_word (b_word), .read_valid (b_rv),
    .entry_valid (b_ev), .write_count (b_wc)
  );

  instr_register_exec #(.DEPTH(4), .OPERAND_W(8)) u_dut_small (
    .clk (clk), .reset (reset),
    .load_en (s_load_en), .write_pointer (s_wp), .opcode (s_opc),
    .operand_a (s_a), .operand_b (s_b),
    .read_en (s_read_en), .read_pointer (s_rp),
    .instruction_word (s_word), .read_valid (s_rv),
    .entry_valid (s_ev), .write_count (s_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural result: plain 64-bit integer arithmetic on sign-extended operands.
  function automatic void model_alu(input int opc, input longint a, input longint b,
                                    output longint r, output bit e);
    r = 0;
    e = 1'b0;
    case (opc)
      0: r = 0;
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      5: r = a * b;
      6: if (b == 0) e = 1'b1; else r = a / b;
      7: if (b == 0) e = 1'b1; else r = a % b;
      default: r = 0;
    endcase
  endfunction

  function automatic logic [132:0] pack_big(input int opc, input longint a, input longint b,
                                            input longint r, input bit e);
    logic [3:0] o;
    o = opc[3:0];
    return {o, a[31:0], b[31:0], r[63:0], e};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem_b[i] = '0;
      val_b[i] = 1'b0;
    end
    exp_word = '0;
    exp_ev   = 1'b0;
    exp_wc   = 0;
  endtask

  // One cycle on the default instance; inputs applied just after an edge,
  // outputs sampled 1 time unit after the following edge.
  task automatic big_op(input bit ld, input int wp, input int opc, input longint a,
                        input longint b, input bit rd, input int rp);
    longint       r;
    bit           e;
    logic [132:0] nw;
    model_alu(opc, a, b, r, e);
    nw = pack_big(opc, a, b, r, e);
    b_load_en = ld;  b_wp = wp[4:0];  b_opc = opc[3:0];
    b_a = a[31:0];   b_b = b[31:0];
    b_read_en = rd;  b_rp = rp[4:0];
    @(posedge clk);
    #1;
    if (rd) begin
      if (ld && (wp == rp)) begin
        exp_word = nw;
        exp_ev   = 1'b1;
      end else begin
        exp_word = mem_b[rp];
        exp_ev   = val_b[rp];
      end
    end
    if (ld) begin
      mem_b[wp] = nw;
      val_b[wp] = 1'b1;
      if (exp_wc < 65535) exp_wc++;
    end
    $display("txn ld=%0d wp=%0d %s a=%0d b=%0d rd=%0d rp=%0d -> word=%h rv=%0d ev=%0d wc=%0d",
             ld, wp, opcode_name(opc[3:0]), a, b, rd, rp, b_word, b_rv, b_ev, b_wc);
    check_val("read_valid", b_rv, rd);
    check_val("instruction_word", b_word, exp_word);
    check_val("entry_valid", b_ev, exp_ev);
    check_val("write_count", b_wc, exp_wc);
    b_load_en = 1'b0;
    b_read_en = 1'b0;
  endtask

  initial begin
    int     ia, ib, sel, wp, rp, n;
    longint a, b;

    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    b_load_en = 0; b_read_en = 0; b_wp = 0; b_rp = 0; b_opc = 0; b_a = 0; b_b = 0;
    s_load_en = 0; s_read_en = 0; s_wp = 0; s_rp = 0; s_opc = 0; s_a = 0; s_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_val("rst_word", b_word, 0);
    check_val("rst_rv", b_rv, 0);
    check_val("rst_ev", b_ev, 0);
    check_val("rst_wc", b_wc, 0);
    check_val("rst_small_word", s_word, 0);

    // Every address reads back empty after reset.
    for (int i = 0; i < 32; i++) big_op(0, 0, 0, 0, 0, 1, i);

    // ALU coverage
    big_op(1, 3, ADD, 7, -9, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 3);
    check_val("add_result", b_word[64:1], 64'hFFFF_FFFF_FFFF_FFFE);
    big_op(1, 5, MULT, -65536, 65536, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 5);
    check_val("mult_result", b_word[64:1], 64'hFFFF_FFFF_0000_0000);
    big_op(1, 6, DIV, -7, 2, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 6);
    check_val("div_result", b_word[64:1], 64'hFFFF_FFFF_FFFF_FFFD);
    big_op(1, 7, MOD, -7, 2, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 7);
    check_val("mod_result", b_word[64:1], 64'hFFFF_FFFF_FFFF_FFFF);
    big_op(1, 8, 9, 123, 456, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 8);
    check_val("rsvd_result", b_word[64:1], 64'h0);
    check_val("rsvd_opc", b_word[132:129], 4'd9);

    // Divide by zero, then recovery on the same address
    big_op(1, 4, DIV, 5, 0, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 4);
    check_val("div0_result", b_word[64:1], 64'h0);
    check_val("div0_err", b_word[0], 1'b1);
    big_op(1, 4, MOD, 5, 0, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 4);
    check_val("mod0_err", b_word[0], 1'b1);
    big_op(1, 4, DIV, 5, 1, 0, 0);
    big_op(0, 0, 0, 0, 0, 1, 4);
    check_val("div1_result", b_word[64:1], 64'd5);
    check_val("div1_err", b_word[0], 1'b0);

    // Write-first bypass onto a never-written address
    big_op(1, 10, PASSA, 42, 0, 1, 10);
    check_val("bypass_op_a", b_word[128:97], 32'd42);
    check_val("bypass_result", b_word[64:1], 64'd42);
    check_val("bypass_ev", b_ev, 1'b1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      ia  = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0)      ib = 0;
      else if (sel == 1) ib = $urandom_range(0, 20) - 10;
      else               ib = $urandom;
      a  = ia;
      b  = ib;
      wp = $urandom_range(0, 31);
      rp = ($urandom_range(0, 3) == 0) ? wp : $urandom_range(0, 31);
      big_op($urandom_range(0, 1), wp, $urandom_range(0, 15), a, b,
             $urandom_range(0, 1), rp);
    end

    // Reset asserted in the middle of a cycle that carries a read
    for (int i = 0; i < 6; i++) big_op(1, i, ADD, i, i * 3, 0, 0);
    b_read_en = 1'b1;
    b_rp = 5'd2;
    #3;
    reset = 1'b1;
    #1;
    check_val("midrst_word", b_word, 0);
    check_val("midrst_rv", b_rv, 0);
    check_val("midrst_ev", b_ev, 0);
    check_val("midrst_wc", b_wc, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_val("midrst_hold_rv", b_rv, 0);
    reset = 1'b0;
    b_read_en = 1'b0;
    big_op(0, 0, 0, 0, 0, 1, 2);
    check_val("postrst_ev", b_ev, 0);
    check_val("postrst_wc", b_wc, 0);

    // Narrow instance: SUB -128,127 and MULT -128*-128
    s_load_en = 1'b1; s_wp = 2'd3; s_opc = SUB; s_a = 8'h80; s_b = 8'h7F;
    @(posedge clk); #1;
    s_wp = 2'd1; s_opc = MULT; s_a = 8'h80; s_b = 8'h80;
    @(posedge clk); #1;
    s_load_en = 1'b0;
    s_read_en = 1'b1; s_rp = 2'd3;
    @(posedge clk); #1;
    $display("txn small read rp=3 -> word=%h rv=%0d ev=%0d wc=%0d", s_word, s_rv, s_ev, s_wc);
    check_val("small_sub_result", s_word[16:1], 16'hFF01);
    check_val("small_sub_opc", s_word[36:33], 4'd4);
    check_val("small_sub_ev", s_ev, 1'b1);
    check_val("small_sub_rv", s_rv, 1'b1);
    s_rp = 2'd1;
    @(posedge clk); #1;
    $display("txn small read rp=1 -> word=%h rv=%0d ev=%0d wc=%0d", s_word, s_rv, s_ev, s_wc);
    check_val("small_mult_result", s_word[16:1], 16'h4000);
    check_val("small_wc", s_wc, 16'd2);
    s_read_en = 1'b0;
    @(posedge clk); #1;
    check_val("small_idle_rv", s_rv, 1'b0);
    check_val("small_hold_word", s_word[16:1], 16'h4000);

    // Saturation of write_count
    n = 2;
    s_load_en = 1'b1;
    while (n < 70000) begin
      s_wp  = 2'($urandom);
      s_opc = 4'($urandom);
      s_a   = 8'($urandom);
      s_b   = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (n == 65534 || n == 65535 || n == 70000) begin
        $display("txn small writes=%0d -> wc=%0d", n, s_wc);
        check_val("sat_wc", s_wc, (n > 65535) ? 65535 : n);
      end
    end
    s_load_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
